// File: rtl/cond_pkg.sv
// Shared types and bit positions for the conditional-execution stage.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-field evaluator: (cond, NZCV) -> pass / illegal encoding.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass,
  output logic       illegal
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass    = 1'b0;
    illegal = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: illegal = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV register, condition test and side-effect gating.
// Optional performance counters enabled by defining COND_UNIT_PERF_EN.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_write,
  input  logic       pcs,
  input  logic       reg_write,
  input  logic       mem_write,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       cond_ex,
  output logic [3:0] flags,
  output logic       cond_illegal
`ifdef COND_UNIT_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_exec,
  output logic [CNT_W-1:0] perf_squash
`endif
);

  logic pass;
  logic illegal;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cond_unit: CNT_W must be at least 1");
  end

  cond_eval u_cond_eval (
    .cond    (cond),
    .flags   (flags),
    .pass    (pass),
    .illegal (illegal)
  );

  assign cond_ex      = instr_valid & pass;
  assign cond_illegal = instr_valid & illegal;
  assign pc_src       = pcs & cond_ex;
  assign reg_write_o  = reg_write & cond_ex & ~no_write;
  assign mem_write_o  = mem_write & cond_ex;

  // Test uses the registered flags, so an instruction that both tests and sets sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= FLAGS_RST;
    end else if (cond_ex) begin
      if (flag_write[FW_NZ]) begin
        flags[FLAG_N] <= alu_flags[FLAG_N];
        flags[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flag_write[FW_CV]) begin
        flags[FLAG_C] <= alu_flags[FLAG_C];
        flags[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

`ifdef COND_UNIT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      perf_exec   <= '0;
      perf_squash <= '0;
    end else begin
      if (cond_ex)
        perf_exec <= perf_exec + CNT_W'(1);
      if (instr_valid && !cond_ex)
        perf_squash <= perf_squash + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit; perf counters checked when COND_UNIT_PERF_EN is defined.
module tb_cond_unit;

  localparam int unsigned TB_CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset, instr_valid, pcs, reg_write, mem_write, no_write;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_write;
  logic       pc_src, reg_write_o, mem_write_o, cond_ex, cond_illegal;
  logic [3:0] flags;
`ifdef COND_UNIT_PERF_EN
  logic                perf_clr;
  logic [TB_CNT_W-1:0] perf_exec, perf_squash;
`endif

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(TB_CNT_W), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .cond(cond),
    .alu_flags(alu_flags), .flag_write(flag_write), .pcs(pcs),
    .reg_write(reg_write), .mem_write(mem_write), .no_write(no_write),
    .pc_src(pc_src), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
    .cond_ex(cond_ex), .flags(flags), .cond_illegal(cond_illegal)
`ifdef COND_UNIT_PERF_EN
    , .perf_clr(perf_clr), .perf_exec(perf_exec), .perf_squash(perf_squash)
`endif
  );

  typedef struct {
    string      tag;
    logic       pc_src, reg_write_o, mem_write_o, cond_ex, cond_illegal;
    logic [3:0] flags;
    logic [TB_CNT_W-1:0] pe, ps;
  } exp_t;

  exp_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [3:0]          m_flags;
  logic [TB_CNT_W-1:0] m_exec, m_squash;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input string tag, input logic rst, input logic v, input logic [3:0] c,
                      input logic [1:0] fw, input logic [3:0] af, input logic p,
                      input logic rw, input logic mw, input logic nw, input logic clr);
    exp_t e, o;
    logic cex;
    @(negedge clk);
    reset = rst; instr_valid = v; cond = c; flag_write = fw; alu_flags = af;
    pcs = p; reg_write = rw; mem_write = mw; no_write = nw;
`ifdef COND_UNIT_PERF_EN
    perf_clr = clr;
`endif
    cex = v && ref_pass(c, m_flags);
    e.tag = tag;
    e.cond_ex = cex;
    e.pc_src = p && cex;
    e.reg_write_o = rw && cex && !nw;
    e.mem_write_o = mw && cex;
    e.cond_illegal = v && (c == 4'hF);
    e.flags = m_flags;
    e.pe = m_exec;
    e.ps = m_squash;
    exp_q.push_back(e);
    #2;
    o = exp_q.pop_front();
    check({o.tag, ".cond_ex"}, 32'(cond_ex), 32'(o.cond_ex));
    check({o.tag, ".pc_src"}, 32'(pc_src), 32'(o.pc_src));
    check({o.tag, ".reg_write_o"}, 32'(reg_write_o), 32'(o.reg_write_o));
    check({o.tag, ".mem_write_o"}, 32'(mem_write_o), 32'(o.mem_write_o));
    check({o.tag, ".cond_illegal"}, 32'(cond_illegal), 32'(o.cond_illegal));
    check({o.tag, ".flags"}, 32'(flags), 32'(o.flags));
`ifdef COND_UNIT_PERF_EN
    check({o.tag, ".perf_exec"}, 32'(perf_exec), 32'(o.pe));
    check({o.tag, ".perf_squash"}, 32'(perf_squash), 32'(o.ps));
`endif
    // advance the model to the state after the coming rising edge
    if (rst) begin
      m_flags = 4'b0000;
    end else if (cex) begin
      if (fw[1]) m_flags[3:2] = af[3:2];
      if (fw[0]) m_flags[1:0] = af[1:0];
    end
    if (rst || clr) begin
      m_exec = '0; m_squash = '0;
    end else begin
      if (cex) m_exec = m_exec + 1'b1;
      if (v && !cex) m_squash = m_squash + 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; cond = 4'hE; flag_write = 2'b00; alu_flags = 4'h0;
    pcs = 1'b0; reg_write = 1'b0; mem_write = 1'b0; no_write = 1'b0;
`ifdef COND_UNIT_PERF_EN
    perf_clr = 1'b0;
`endif
    m_flags = 4'b0000; m_exec = '0; m_squash = '0;
    @(posedge clk);

    //          tag        rst   v     cond   fw     af     pcs   rw    mw    nw    clr
    step("rst_hold",  1'b1, 1'b1, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst_rel",   1'b0, 1'b1, 4'hE, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("set_z",     1'b0, 1'b1, 4'hE, 2'b11, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("eq_pass",   1'b0, 1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ne_fail",   1'b0, 1'b1, 4'h1, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("set_1010",  1'b0, 1'b1, 4'hE, 2'b11, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("part_cv",   1'b0, 1'b1, 4'hE, 2'b01, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ge_pass",   1'b0, 1'b1, 4'hA, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("part_nz",   1'b0, 1'b1, 4'hE, 2'b10, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("clr_all",   1'b0, 1'b1, 4'hE, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("squash_fw", 1'b0, 1'b1, 4'h0, 2'b11, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("after_sq",  1'b0, 1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("cmp_nw",    1'b0, 1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("illegal",   1'b0, 1'b1, 4'hF, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("bubble",    1'b0, 1'b0, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("set_ffff",  1'b0, 1'b1, 4'hE, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tst_set",   1'b0, 1'b1, 4'h0, 2'b11, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid_rst",   1'b1, 1'b1, 4'hE, 2'b11, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst",  1'b0, 1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    step("pc_clr",    1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++)
      step("pc_exec", 1'b0, 1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("pc_sq",   1'b0, 1'b1, 4'hF, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pc_clrex",  1'b0, 1'b1, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("pc_after",  1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), r[3:0], r[5:4],
           r[9:6], r[10], r[11], r[12], r[13], ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
